// File: rtl/mul_chain_sched.sv
// Sequencing controller for the six-lane bf16 multiplier chain: cuts operand jobs into chain passes.
// Optional watchdog and drain of aborted jobs are enabled with MCS_TIMEOUT_EN.
module mul_chain_sched #(
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [15:0] ONE_BF16    = 16'h3F80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [15:0]  op_data,
    input  logic         op_last,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [15:0]  res_data,
    output logic         res_err,
    output logic [191:0] chain_ins,
    output logic         chain_stb,
    output logic [1:0]   chain_mode,
    input  logic [95:0]  chain_out,
    input  logic [5:0]   chain_out_stbs,
    output logic         busy,
    output logic [2:0]   state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid/data are held by the source until that edge, ready never depends on valid.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4,
        DRAIN = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] slots [0:5];
    logic [2:0]  cnt;
    logic [2:0]  lane;
    logic        more;

    logic        accept;
    logic [2:0]  cnt_inc;
    logic        lane_stb;
    logic [15:0] lane_val;

    assign accept    = op_valid && op_ready;
    assign cnt_inc   = cnt + 3'd1;
    assign lane_stb  = chain_out_stbs[lane];
    assign lane_val  = chain_out[{lane, 4'b0000} +: 16];
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Operand fields are scattered across the chain's input bus; every unused field multiplies by 1.0.
    assign chain_ins = {ONE_BF16, ONE_BF16, ONE_BF16, slots[5],
                        ONE_BF16, slots[4], ONE_BF16, slots[3],
                        ONE_BF16, slots[2], slots[0], slots[1]};

    function automatic logic [1:0] mode_of(input logic [2:0] n);
        case (n)
            3'd3:       mode_of = 2'd1;
            3'd4:       mode_of = 2'd2;
            3'd5, 3'd6: mode_of = 2'd3;
            default:    mode_of = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] lane_of(input logic [2:0] n);
        case (n)
            3'd3:       lane_of = 3'd1;
            3'd4:       lane_of = 3'd2;
            3'd5, 3'd6: lane_of = 3'd4;
            default:    lane_of = 3'd0;
        endcase
    endfunction

`ifdef MCS_TIMEOUT_EN
    localparam int              WD_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_END = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd;
    logic            err_q;
    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            op_ready   <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= 16'h0000;
            chain_stb  <= 1'b0;
            chain_mode <= 2'd0;
            lane       <= 3'd0;
            cnt        <= 3'd0;
            more       <= 1'b0;
            for (int i = 0; i < 6; i++) slots[i] <= ONE_BF16;
`ifdef MCS_TIMEOUT_EN
            wd         <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    op_ready <= 1'b1;
                    if (accept) begin
                        slots[0] <= op_data;
                        for (int i = 1; i < 6; i++) slots[i] <= ONE_BF16;
                        cnt  <= 3'd1;
                        more <= 1'b0;
                        if (op_last) begin
                            op_ready   <= 1'b0;
                            chain_stb  <= 1'b1;
                            chain_mode <= mode_of(3'd1);
                            lane       <= lane_of(3'd1);
                            state      <= ISSUE;
                        end else begin
                            state <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (accept) begin
                        slots[cnt] <= op_data;
                        cnt        <= cnt_inc;
                        if (op_last || cnt_inc == 3'd6) begin
                            op_ready   <= 1'b0;
                            more       <= !op_last;
                            chain_stb  <= 1'b1;
                            chain_mode <= mode_of(cnt_inc);
                            lane       <= lane_of(cnt_inc);
                            state      <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    chain_stb <= 1'b0;
`ifdef MCS_TIMEOUT_EN
                    wd        <= '0;
`endif
                    state     <= WAIT;
                end

                WAIT: begin
`ifdef MCS_TIMEOUT_EN
                    wd <= wd + 1'b1;
`endif
                    if (lane_stb) begin
                        if (more) begin
                            // Partial product becomes the first factor of the next pass.
                            slots[0] <= lane_val;
                            for (int i = 1; i < 6; i++) slots[i] <= ONE_BF16;
                            cnt      <= 3'd1;
                            more     <= 1'b0;
                            op_ready <= 1'b1;
                            state    <= FILL;
                        end else begin
                            res_data  <= lane_val;
                            res_valid <= 1'b1;
                            state     <= OUT;
                        end
                    end
`ifdef MCS_TIMEOUT_EN
                    else if (wd == WD_END) begin
                        res_data  <= 16'h7FC0;
                        err_q     <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end
`endif
                end

                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
`ifdef MCS_TIMEOUT_EN
                        err_q     <= 1'b0;
                        // An aborted multi-pass job still has operands in flight up to op_last.
                        state     <= more ? DRAIN : IDLE;
`else
                        state     <= IDLE;
`endif
                    end
                end

`ifdef MCS_TIMEOUT_EN
                DRAIN: begin
                    if (accept && op_last) begin
                        more  <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif

                default: begin
                    op_ready  <= 1'b0;
                    chain_stb <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_chain_sched.sv
// Directed bench for mul_chain_sched with a behavioural chain responder.
module tb_mul_chain_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic         op_ready;
    logic [15:0]  op_data;
    logic         op_last;
    logic         res_valid;
    logic         res_ready;
    logic [15:0]  res_data;
    logic         res_err;
    logic [191:0] chain_ins;
    logic         chain_stb;
    logic [1:0]   chain_mode;
    logic [95:0]  chain_out;
    logic [5:0]   chain_out_stbs;
    logic         busy;
    logic [2:0]   state_dbg;

    localparam logic [191:0] ALL_ONE = {12{16'h3F80}};

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0]  exp_q [$];
    logic [15:0]  rsp_q [$];
    logic [1:0]   cap_mode [$];
    logic [191:0] cap_ins [$];
    int           stb_count = 0;
    logic [15:0]  job_ops [0:15];

    mul_chain_sched #(.TIMEOUT_CYC(64), .ONE_BF16(16'h3F80)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_last(op_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .chain_ins(chain_ins), .chain_stb(chain_stb), .chain_mode(chain_mode),
        .chain_out(chain_out), .chain_out_stbs(chain_out_stbs),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // chain responder: junk strobes in the ISSUE cycle and on other lanes, then the real result
    initial begin : responder
        int          rl;
        logic [15:0] v;
        chain_out      = '0;
        chain_out_stbs = '0;
        forever begin
            @(negedge clk);
            if (chain_stb === 1'b1) begin
                stb_count++;
                cap_mode.push_back(chain_mode);
                cap_ins.push_back(chain_ins);
                case (chain_mode)
                    2'd1:    rl = 1;
                    2'd2:    rl = 2;
                    2'd3:    rl = 4;
                    default: rl = 0;
                endcase
                chain_out      = {6{16'hBAD1}};
                chain_out_stbs = 6'h3F;
                @(negedge clk);
                chain_out_stbs = 6'h3F & ~(6'h01 << rl);
                @(negedge clk);
                chain_out_stbs = '0;
                if (rsp_q.size() > 0) begin
                    v = rsp_q.pop_front();
                    @(negedge clk);
                    chain_out              = {6{16'hBAD2}};
                    chain_out[rl*16 +: 16] = v;
                    chain_out_stbs         = 6'h01 << rl;
                    @(negedge clk);
                    chain_out_stbs = '0;
                end
            end
        end
    end

    // driver tasks (called at a negedge)
    task automatic send_op(input logic [15:0] d, input logic last);
        int w = 0;
        op_valid = 1'b1;
        op_data  = d;
        op_last  = last;
        while (op_ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_accept_timeout: op_ready=%b required 1", op_ready);
        end
        @(negedge clk);
        op_valid = 1'b0;
        op_last  = 1'b0;
    endtask

    task automatic send_job(input int n);
        for (int i = 0; i < n; i++) send_op(job_ops[i], i == n - 1);
    endtask

    task automatic get_result(input string name);
        int          w = 0;
        logic [16:0] exp;
        res_ready = 1'b1;
        while (res_valid !== 1'b1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (w >= 500) begin
            n_fail++;
            $display("FAIL %s_res_timeout: res_valid=%b required 1", name, res_valid);
        end else if ({res_err, res_data} !== exp) begin
            n_fail++;
            $display("FAIL %s_res: err/data=%h required %h", name, {res_err, res_data}, exp);
        end
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic clear_caps();
        cap_mode.delete();
        cap_ins.delete();
        stb_count = 0;
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if (op_ready !== 1'b0) begin n_fail++; $display("FAIL %s_op_ready: got %b required 0", name, op_ready); end
        n_checks++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL %s_res_valid: got %b required 0", name, res_valid); end
        n_checks++;
        if (res_data !== 16'h0000) begin n_fail++; $display("FAIL %s_res_data: got %h required 0000", name, res_data); end
        n_checks++;
        if (res_err !== 1'b0) begin n_fail++; $display("FAIL %s_res_err: got %b required 0", name, res_err); end
        n_checks++;
        if (chain_stb !== 1'b0) begin n_fail++; $display("FAIL %s_chain_stb: got %b required 0", name, chain_stb); end
        n_checks++;
        if (chain_mode !== 2'd0) begin n_fail++; $display("FAIL %s_chain_mode: got %0d required 0", name, chain_mode); end
        n_checks++;
        if (chain_ins !== ALL_ONE) begin n_fail++; $display("FAIL %s_chain_ins: got %h required %h", name, chain_ins, ALL_ONE); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b required 0", name, busy); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_op_ready_rise: got %b required 1", op_ready); end
    endtask

    task automatic test_two_ops();
        logic [191:0] e = ALL_ONE;
        clear_caps();
        e[31:16] = 16'h4000;
        e[15:0]  = 16'h4040;
        rsp_q.push_back(16'h40C0);
        exp_q.push_back({1'b0, 16'h40C0});
        job_ops[0] = 16'h4000;
        job_ops[1] = 16'h4040;
        send_job(2);
        get_result("two_ops");
        n_checks++;
        if (stb_count !== 1) begin n_fail++; $display("FAIL two_ops_stb_count: got %0d required 1", stb_count); end
        n_checks++;
        if (cap_mode.size() != 1 || cap_mode[0] !== 2'd0) begin n_fail++; $display("FAIL two_ops_mode: passes=%0d required mode 0", cap_mode.size()); end
        n_checks++;
        if (cap_ins.size() != 1 || cap_ins[0] !== e) begin n_fail++; $display("FAIL two_ops_ins: got %h required %h", chain_ins, e); end
    endtask

    task automatic test_single();
        logic [191:0] e = ALL_ONE;
        clear_caps();
        e[31:16] = 16'h4040;
        rsp_q.push_back(16'h4040);
        exp_q.push_back({1'b0, 16'h4040});
        job_ops[0] = 16'h4040;
        send_job(1);
        get_result("single");
        n_checks++;
        if (cap_mode.size() != 1 || cap_mode[0] !== 2'd0) begin n_fail++; $display("FAIL single_mode: passes=%0d required mode 0", cap_mode.size()); end
        n_checks++;
        if (cap_ins.size() != 1 || cap_ins[0] !== e) begin n_fail++; $display("FAIL single_ins: got %h required %h", chain_ins, e); end
    endtask

    task automatic test_six();
        logic [191:0] e = ALL_ONE;
        clear_caps();
        e[31:16] = 16'h4000; e[15:0] = 16'h4000; e[47:32] = 16'h4000;
        e[79:64] = 16'h4000; e[111:96] = 16'h4000; e[143:128] = 16'h4000;
        rsp_q.push_back(16'h4280);
        exp_q.push_back({1'b0, 16'h4280});
        for (int i = 0; i < 6; i++) job_ops[i] = 16'h4000;
        send_job(6);
        get_result("six");
        n_checks++;
        if (cap_mode.size() != 1 || cap_mode[0] !== 2'd3) begin n_fail++; $display("FAIL six_mode: passes=%0d required one pass mode 3", cap_mode.size()); end
        n_checks++;
        if (cap_ins.size() != 1 || cap_ins[0] !== e) begin n_fail++; $display("FAIL six_ins: got %h required %h", chain_ins, e); end
    endtask

    task automatic test_eight();
        logic [191:0] e0 = ALL_ONE;
        logic [191:0] e1 = ALL_ONE;
        clear_caps();
        e0[31:16] = 16'h4000; e0[15:0] = 16'h4000; e0[47:32] = 16'h4000;
        e0[79:64] = 16'h4000; e0[111:96] = 16'h4000; e0[143:128] = 16'h4000;
        e1[31:16] = 16'h4280; e1[15:0] = 16'h4000; e1[47:32] = 16'h4000;
        rsp_q.push_back(16'h4280);
        rsp_q.push_back(16'h4380);
        exp_q.push_back({1'b0, 16'h4380});
        for (int i = 0; i < 8; i++) job_ops[i] = 16'h4000;
        send_job(8);
        get_result("eight");
        n_checks++;
        if (stb_count !== 2) begin n_fail++; $display("FAIL eight_stb_count: got %0d required 2", stb_count); end
        n_checks++;
        if (cap_mode.size() != 2 || cap_mode[0] !== 2'd3 || cap_mode[1] !== 2'd1)
            begin n_fail++; $display("FAIL eight_modes: passes=%0d required modes 3 then 1", cap_mode.size()); end
        n_checks++;
        if (cap_ins.size() != 2 || cap_ins[0] !== e0 || cap_ins[1] !== e1)
            begin n_fail++; $display("FAIL eight_ins: last=%h required second pass %h", chain_ins, e1); end
    endtask

    task automatic test_hold();
        int w = 0;
        int bad = 0;
        rsp_q.push_back(16'h40C0);
        exp_q.push_back({1'b0, 16'h40C0});
        job_ops[0] = 16'h4000;
        job_ops[1] = 16'h4040;
        res_ready = 1'b0;
        send_job(2);
        while (res_valid !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        op_valid = 1'b1;
        op_data  = 16'h1234;
        op_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b1 || res_data !== 16'h40C0 || op_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        op_valid = 1'b0;
        op_last  = 1'b0;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL hold_stable: %0d bad cycles required 0 (data=%h op_ready=%b)", bad, res_data, op_ready); end
        get_result("hold");
        n_checks++;
        if (busy !== 1'b0 || op_ready !== 1'b1) begin n_fail++; $display("FAIL hold_idle: busy=%b op_ready=%b required 0/1", busy, op_ready); end
    endtask

    task automatic test_reset_wait();
        int w = 0;
        clear_caps();
        for (int i = 0; i < 4; i++) job_ops[i] = 16'h4000;
        send_job(4);
        while (state_dbg !== 3'd3 && w < 50) begin @(negedge clk); w++; end
        n_checks++;
        if (state_dbg !== 3'd3 || chain_mode !== 2'd2) begin n_fail++; $display("FAIL rstwait_reach: state=%0d mode=%0d required 3/2", state_dbg, chain_mode); end
        rst = 1'b0;
        #1;
        check_reset_values("rstwait");
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || op_ready !== 1'b1 || res_valid !== 1'b0)
            begin n_fail++; $display("FAIL rstwait_recover: busy=%b op_ready=%b res_valid=%b required 0/1/0", busy, op_ready, res_valid); end
    endtask

`ifdef MCS_TIMEOUT_EN
    task automatic test_timeout();
        clear_caps();
        rsp_q.delete();
        exp_q.push_back({1'b1, 16'h7FC0});
        for (int i = 0; i < 8; i++) job_ops[i] = 16'h4000;
        fork
            send_job(8);
            get_result("timeout");
        join
        n_checks++;
        if (busy !== 1'b0 || op_ready !== 1'b1 || res_err !== 1'b0)
            begin n_fail++; $display("FAIL timeout_drain: busy=%b op_ready=%b err=%b required 0/1/0", busy, op_ready, res_err); end
    endtask
`endif

    initial begin : main
        op_valid  = 1'b0;
        op_data   = 16'h0000;
        op_last   = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_two_ops();
        test_single();
        test_six();
        test_eight();
        test_hold();
        test_reset_wait();
`ifdef MCS_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_chain_sched.md
# mul_chain_sched

Sequencing controller for the six-lane bf16 multiplier chain. It accepts product-node jobs as a stream of bf16 operands of any length. Each job is cut into chain passes of at most six factors, and the controller picks the chain mode for each pass. For jobs longer than one pass, it feeds the partial product back as the first factor of the next pass. It returns one bf16 product per job over a valid/ready handshake. It sits between the probabilistic-circuit node dispatcher and a single `mul_chain_bf16` instance.

## Interface
- `TIMEOUT_CYC`, default 64: watchdog limit in cycles for a chain result. Only used when `MCS_TIMEOUT_EN` is defined.
- `ONE_BF16`, default 16'h3F80: pad value (1.0) driven on all unused 16-bit operand fields.

Ports (one per line: name, direction, width, meaning):
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  operand available.
- `op_ready`  out  1  controller accepts an operand.
- `op_data`  in  16  bf16 operand.
- `op_last`  in  1  marks the final operand of the job.
- `res_valid`  out  1  job product available.
- `res_ready`  in  1  downstream accepts the product.
- `res_data`  out  16  bf16 product of all operands of the job.
- `res_err`  out  1  set with `res_valid` when the watchdog aborted the job. Tied 0 without `MCS_TIMEOUT_EN`.
- `chain_ins`  out  192  drives `mul_ins` of the chain.
- `chain_stb`  out  1  drives `mul_stb` of the chain.
- `chain_mode`  out  2  drives `mode` of the chain.
- `chain_out`  in  96  chain `outputs`.
- `chain_out_stbs`  in  6  chain `final_output_stbs`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FILL, ISSUE, WAIT, OUT.
- IDLE: `op_ready`=1. The first accepted operand goes into slot 0, `cnt`=1, and the controller moves to FILL. If that operand also has `op_last`, it moves straight to ISSUE.
- FILL: `op_ready`=1 while `cnt`<6. Each accepted operand is written to slot `cnt`, then `cnt`++.
  - Go to ISSUE when `op_last` is accepted or when `cnt` reaches 6.
  - If `cnt` reaches 6 without `op_last`, set `more`=1.
- Slot-to-field map:
  - slot0 → `chain_ins[31:16]`, slot1 → `[15:0]`, slot2 → `[47:32]`, slot3 → `[79:64]`, slot4 → `[111:96]`, slot5 → `[143:128]`.
  - Every unfilled slot and every other 16-bit field is driven with `ONE_BF16`.
- Mode selected from `cnt` at ISSUE:
  - `cnt` 1 or 2 → mode 0, result lane 0.
  - `cnt` 3 → mode 1, result lane 1.
  - `cnt` 4 → mode 2, result lane 2.
  - `cnt` 5 or 6 → mode 3, result lane 4.
- ISSUE: pulse `chain_stb` for exactly one cycle, latch the result lane `L`, then go to WAIT. `chain_mode` and `chain_ins` are held stable from ISSUE until the WAIT exit.
- WAIT: wait for `chain_out_stbs[L]`. Strobes on other lanes are ignored.
  - On the strobe, capture `chain_out[16*L+15:16*L]`.
  - If `more`=1: write the captured value to slot 0, set `cnt`=1, clear `more`, go to FILL. A continuation pass therefore takes at most 5 new operands.
  - If `more`=0: load `res_data` and go to OUT.
- OUT: `res_valid`=1. On `res_valid && res_ready`, go to IDLE.
- Products are bit-exact chain outputs. The controller does no arithmetic; padding with 1.0 must not change the result.

## Timing
- Reset values: `op_ready`=0, `res_valid`=0, `res_data`=0, `res_err`=0, `chain_stb`=0, `chain_mode`=0, `chain_ins`=all fields `ONE_BF16`, `busy`=0, state IDLE. `op_ready` rises in the first cycle after `rst` deasserts.
- A reset assertion in any state aborts the job immediately. Late chain strobes after reset are ignored because the controller is in IDLE.
- Job latency is fill cycles + 1 (ISSUE) + chain latency + 1 (capture), per pass, plus the OUT handshake.
- No new operand is accepted during ISSUE, WAIT or OUT.
- `res_data` and `res_err` are stable while `res_valid`=1 and `res_ready`=0.
- `op_valid` with `op_ready`=0 has no effect. `op_last` without `op_valid` is ignored.
- A chain strobe arriving in the same cycle as ISSUE is ignored. Only strobes seen in WAIT count.

## Configuration
- `MCS_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYC` without the lane strobe, the job is aborted: `res_data`=16'h7FC0 (NaN), `res_err`=1, state goes to OUT.
  - Any operands of the aborted job that have not yet been sent are still consumed and discarded up to `op_last`. A DRAIN state is entered from OUT only when `more` was 1.
- `MCS_TIMEOUT_EN` undefined: no counter and no DRAIN state; `res_err` is tied to 0 and WAIT waits indefinitely.

## Test plan
- Job {0x4000, 0x4040} (2.0 × 3.0) → mode 0, one `chain_stb`, `res_data`=0x40C0.
- Single operand {0x4040} with `op_last` → mode 0, slot 1 = 0x3F80, `res_data`=0x4040.
- Six × 0x4000 → mode 3, result lane 4, `res_data`=0x4280 (64.0).
- Eight × 0x4000 → two passes: mode 3, then mode 1 with slot 0 = 0x4280; `res_data`=0x4380 (256.0); exactly 2 `chain_stb` pulses.
- Hold `res_ready`=0 for 10 cycles in OUT → `res_data` stable and `op_ready`=0; reset asserted mid-WAIT → all outputs return to their reset values.
- With `MCS_TIMEOUT_EN`, chain never strobes → after `TIMEOUT_CYC` cycles, `res_valid`=1, `res_err`=1, `res_data`=0x7FC0.
